// File: rtl/multimode_counter.sv
// rtl/multimode_counter.sv - bounded up/down counter with wrap/saturate, load clamp and oneshot halt
//
// Purpose:
//   Counts between MIN and MAX in either direction. At a bound the counter
//   either wraps (SATURATE=0, pulsing carry for one cycle) or holds
//   (SATURATE=1). In oneshot mode it stops on the terminal value and parks
//   in HALT until a load or reset.
//
// Ports:
//   clk      in   clock, all state changes on the rising edge
//   reset_n  in   asynchronous active-low reset
//   ce       in   count enable
//   up       in   direction, 1 = up, 0 = down
//   load     in   synchronous load strobe (highest priority after reset)
//   preset   in   load value, clamped into MIN..MAX
//   oneshot  in   halt at the terminal value instead of wrapping
//   out      out  registered count value
//   tc       out  combinational terminal-count flag for the current direction
//   carry    out  registered one-cycle wrap pulse
//   done     out  registered, high while halted

module multimode_counter #(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] MAX      = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0] MIN      = '0,
  parameter int               SATURATE = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ce,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] preset,
  input  logic             oneshot,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             carry,
  output logic             done
);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  localparam bit WRAP_MODE = (SATURATE == 0);

  state_t           r_state;
  logic [WIDTH-1:0] r_out;
  logic             r_carry;
  logic             r_done;

  state_t           w_next_state;
  logic [WIDTH-1:0] w_next_out;
  logic             w_next_carry;

  logic [WIDTH-1:0] w_term;
  logic             w_at_term;
  logic [WIDTH-1:0] w_wrap_val;
  logic [WIDTH-1:0] w_step_val;
  logic             w_preset_above;
  logic             w_preset_below;
  logic [WIDTH-1:0] w_preset_clamped;

  // Clamp comparisons are only built when the bound can actually be crossed;
  // a full-range bound would otherwise become a constant-false compare.
  if (MAX == {WIDTH{1'b1}}) begin : g_max_full
    assign w_preset_above = 1'b0;
  end else begin : g_max_part
    assign w_preset_above = (preset > MAX);
  end

  if (MIN == '0) begin : g_min_zero
    assign w_preset_below = 1'b0;
  end else begin : g_min_part
    assign w_preset_below = (preset < MIN);
  end

  assign w_preset_clamped = w_preset_above ? MAX :
                            w_preset_below ? MIN : preset;

  // Terminal value follows the live direction input, so a direction change
  // is seen on the very next enabled edge.
  assign w_term     = up ? MAX : MIN;
  assign w_at_term  = (r_out == w_term);
  assign w_wrap_val = up ? MIN : MAX;
  assign w_step_val = up ? (r_out + 1'b1) : (r_out - 1'b1);

  always_comb begin
    w_next_state = r_state;
    w_next_out   = r_out;
    w_next_carry = 1'b0;

    if (load) begin
      w_next_out   = w_preset_clamped;
      w_next_state = ST_RUN;
    end else if ((r_state == ST_RUN) && ce) begin
      if (oneshot && w_at_term) begin
        // Already sitting on the terminal value: stop here, never wrap.
        w_next_state = ST_HALT;
      end else if (w_at_term) begin
        if (WRAP_MODE) begin
          w_next_out   = w_wrap_val;
          w_next_carry = 1'b1;
        end
      end else begin
        w_next_out = w_step_val;
        if (oneshot && (w_step_val == w_term)) begin
          w_next_state = ST_HALT;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_RUN;
      r_out   <= MIN;
      r_carry <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_out   <= w_next_out;
      r_carry <= w_next_carry;
      r_done  <= (w_next_state == ST_HALT);
    end
  end

  assign out   = r_out;
  assign tc    = w_at_term;
  assign carry = r_carry;
  assign done  = r_done;

endmodule

// File: tb/tb_multimode_counter.sv
// tb/tb_multimode_counter.sv - randomized and directed checks of multimode_counter against a range model
//
// Three instances share stimulus: wrap 0..9, saturate 0..9, and wrap 3..12
// on a 4-bit counter. A reference model tracks each one using offset-modulo
// arithmetic over the range.

module tb_multimode_counter;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       ce;
  logic       up;
  logic       load;
  logic       oneshot;
  logic [7:0] preset;

  logic [7:0] out0;
  logic [7:0] out1;
  logic [3:0] out2;
  logic [2:0] tc_v;
  logic [2:0] carry_v;
  logic [2:0] done_v;

  int n_tests = 0;
  int n_fail  = 0;

  int P_MIN[3] = '{0, 0, 3};
  int P_MAX[3] = '{9, 9, 12};
  int P_SAT[3] = '{0, 1, 0};
  int P_W[3]   = '{8, 8, 4};

  int m_out[3];
  bit m_halt[3];
  bit m_carry[3];

  always #5 clk = ~clk;

  multimode_counter #(.WIDTH(8), .MAX(8'd9), .MIN(8'd0), .SATURATE(0)) u_wrap (
    .clk(clk), .reset_n(reset_n), .ce(ce), .up(up), .load(load),
    .preset(preset), .oneshot(oneshot), .out(out0),
    .tc(tc_v[0]), .carry(carry_v[0]), .done(done_v[0])
  );

  multimode_counter #(.WIDTH(8), .MAX(8'd9), .MIN(8'd0), .SATURATE(1)) u_sat (
    .clk(clk), .reset_n(reset_n), .ce(ce), .up(up), .load(load),
    .preset(preset), .oneshot(oneshot), .out(out1),
    .tc(tc_v[1]), .carry(carry_v[1]), .done(done_v[1])
  );

  multimode_counter #(.WIDTH(4), .MAX(4'd12), .MIN(4'd3), .SATURATE(0)) u_off (
    .clk(clk), .reset_n(reset_n), .ce(ce), .up(up), .load(load),
    .preset(preset[3:0]), .oneshot(oneshot), .out(out2),
    .tc(tc_v[2]), .carry(carry_v[2]), .done(done_v[2])
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int get_out(input int k);
    case (k)
      0:       return int'(out0);
      1:       return int'(out1);
      default: return int'(out2);
    endcase
  endfunction

  task automatic m_reset();
    for (int k = 0; k < 3; k++) begin
      m_out[k]   = P_MIN[k];
      m_halt[k]  = 1'b0;
      m_carry[k] = 1'b0;
    end
  endtask

  task automatic m_edge();
    for (int k = 0; k < 3; k++) begin
      int rng;
      int pv;
      int term;
      int off;
      bit at_term;
      rng     = P_MAX[k] - P_MIN[k] + 1;
      pv      = int'(preset) % (1 << P_W[k]);
      term    = up ? P_MAX[k] : P_MIN[k];
      at_term = (m_out[k] == term);
      m_carry[k] = 1'b0;
      if (!reset_n) begin
        m_out[k]  = P_MIN[k];
        m_halt[k] = 1'b0;
      end else if (load) begin
        m_out[k]  = (pv > P_MAX[k]) ? P_MAX[k] : (pv < P_MIN[k]) ? P_MIN[k] : pv;
        m_halt[k] = 1'b0;
      end else if (ce && !m_halt[k]) begin
        if (oneshot && at_term) begin
          m_halt[k] = 1'b1;
        end else if (!(at_term && P_SAT[k] != 0)) begin
          off = m_out[k] - P_MIN[k];
          off = up ? (off + 1) % rng : (off + rng - 1) % rng;
          m_out[k]   = P_MIN[k] + off;
          m_carry[k] = at_term;
          if (oneshot && m_out[k] == term) m_halt[k] = 1'b1;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("%s/u%0d/out", tag, k), get_out(k), m_out[k]);
      check($sformatf("%s/u%0d/carry", tag, k), int'(carry_v[k]), int'(m_carry[k]));
      check($sformatf("%s/u%0d/done", tag, k), int'(done_v[k]), int'(m_halt[k]));
      check($sformatf("%s/u%0d/tc", tag, k), int'(tc_v[k]),
            int'(m_out[k] == (up ? P_MAX[k] : P_MIN[k])));
    end
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    m_edge();
    #1;
    check_all(tag);
  endtask

  initial begin
    int seq35[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
    int seq36[3]  = '{0, 9, 8};
    int car36[3]  = '{0, 1, 0};

    reset_n = 1'b1; ce = 1'b0; up = 1'b1; load = 1'b0; oneshot = 1'b0; preset = 8'd0;
    #1 reset_n = 1'b0;
    m_reset();
    #2 check_all("reset");
    ce = 1'b1; load = 1'b1; preset = 8'd5;
    tick("reset_hold");

    // wrap up 0..9
    #2 reset_n = 1'b1; load = 1'b0; ce = 1'b1; up = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick("wrap_up");
      check("wrap_up_seq", int'(out0), seq35[i]);
      check("wrap_up_carry", int'(carry_v[0]), int'(seq35[i] == 0));
    end

    // wrap down after loading 1
    load = 1'b1; preset = 8'd1; ce = 1'b0;
    tick("load1");
    load = 1'b0; up = 1'b0; ce = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick("wrap_dn");
      check("wrap_dn_seq", int'(out0), seq36[i]);
      check("wrap_dn_carry", int'(carry_v[0]), car36[i]);
    end

    // saturation on the hold instance
    load = 1'b1; preset = 8'd8; ce = 1'b0; up = 1'b1;
    tick("load8");
    load = 1'b0; ce = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick("sat");
      check("sat_out", int'(out1), 9);
      check("sat_tc", int'(tc_v[1]), 1);
      check("sat_carry", int'(carry_v[1]), 0);
    end

    // oneshot: 7 -> 8 -> 9, then parked
    oneshot = 1'b1; load = 1'b1; preset = 8'd7; ce = 1'b0;
    tick("load7");
    load = 1'b0; ce = 1'b1; up = 1'b1;
    tick("os8");
    check("os_out8", int'(out0), 8);
    tick("os9");
    check("os_out9", int'(out0), 9);
    check("os_done", int'(done_v[0]), 1);
    for (int i = 0; i < 5; i++) begin
      tick("os_hold");
      check("os_hold_out", int'(out0), 9);
    end
    oneshot = 1'b0;
    tick("os_drop");
    check("os_drop_done", int'(done_v[0]), 1);
    load = 1'b1; preset = 8'd3;
    tick("os_reload");
    check("os_reload_out", int'(out0), 3);
    check("os_reload_done", int'(done_v[0]), 0);

    // load priority over count with clamp
    load = 1'b1; ce = 1'b1; up = 1'b1; preset = 8'd200;
    tick("load_clamp");
    check("load_clamp_out", int'(out0), 9);
    load = 1'b0;

    // async reset while halted, between edges
    oneshot = 1'b1;
    tick("halt_at9");
    check("halt_done", int'(done_v[0]), 1);
    #3 reset_n = 1'b0;
    m_reset();
    #1 check("areset_out", int'(out0), 0);
    check("areset_done", int'(done_v[0]), 0);
    check_all("areset");
    reset_n = 1'b1; oneshot = 1'b0; ce = 1'b1; up = 1'b1;
    tick("release");
    check("release_first", int'(out0), 1);

    // async reset mid-count at 5
    for (int i = 0; i < 4; i++) tick("to5");
    check("mid_at5", int'(out0), 5);
    #3 reset_n = 1'b0;
    m_reset();
    #1 check("mid_reset_out", int'(out0), 0);
    reset_n = 1'b1;

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        reset_n = 1'b0;
        m_reset();
      end else begin
        reset_n = 1'b1;
      end
      load    = ($urandom_range(0, 9) == 0);
      preset  = 8'($urandom_range(0, 255));
      ce      = ($urandom_range(0, 3) != 0);
      up      = 1'($urandom);
      oneshot = ($urandom_range(0, 3) == 0);
      tick("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
